// File: rtl/vid_cnt11.sv
// Programmable-period video timing counter with terminal-count pulse,
// set/clear compare match pulses and a registered window flag.
module vid_cnt11 #(
   parameter int                WIDTH      = 11,
   parameter logic [WIDTH-1:0]  PERIOD_RST = 11'h7FF
) (
   input  logic             sys_clk,
   input  logic             reset,
   input  logic             cnt_en,
   input  logic [WIDTH-1:0] din,
   input  logic             period_wr,
   input  logic             set_wr,
   input  logic             clr_wr,
   input  logic             cnt_clr,
   output logic [WIDTH-1:0] cnt,
   output logic             tc,
   output logic             win,
   output logic             match_set,
   output logic             match_clr
);

   localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ONES_C = {WIDTH{1'b1}};

   logic [WIDTH-1:0] cnt_r;
   logic [WIDTH-1:0] period_r;
   logic [WIDTH-1:0] setv_r;
   logic [WIDTH-1:0] clrv_r;
   logic             tc_r;
   logic             win_r;
   logic             match_set_r;
   logic             match_clr_r;

   logic [WIDTH-1:0] cnt_nxt_s;
   logic             tc_nxt_s;
   logic             win_nxt_s;
   logic             hit_set_s;
   logic             hit_clr_s;

   // Next count and terminal-count; an exact period compare means a period
   // rewritten below the count lets the counter run through 7FF silently.
   always_comb begin
      cnt_nxt_s = cnt_r;
      tc_nxt_s  = 1'b0;
      if (cnt_clr) begin
         cnt_nxt_s = ZERO_C;
         tc_nxt_s  = 1'b0;
      end else if (cnt_en && (cnt_r == period_r)) begin
         cnt_nxt_s = ZERO_C;
         tc_nxt_s  = 1'b1;
      end else if (cnt_en) begin
         cnt_nxt_s = cnt_r + ONE_C;
         tc_nxt_s  = 1'b0;
      end else begin
         cnt_nxt_s = cnt_r;
         tc_nxt_s  = 1'b0;
      end
   end

   // Compare matches on the pre-update count and the window set/clear decision.
   always_comb begin
      hit_set_s = cnt_en & ~cnt_clr & (cnt_r == setv_r);
      hit_clr_s = cnt_en & ~cnt_clr & (cnt_r == clrv_r);
      win_nxt_s = win_r;
      if (hit_clr_s) begin
         win_nxt_s = 1'b0;
      end else if (hit_set_s) begin
         win_nxt_s = 1'b1;
      end else begin
         win_nxt_s = win_r;
      end
   end

   // Counter, pulse and window flops.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         cnt_r       <= ZERO_C;
         tc_r        <= 1'b0;
         win_r       <= 1'b0;
         match_set_r <= 1'b0;
         match_clr_r <= 1'b0;
      end else begin
         cnt_r       <= cnt_nxt_s;
         tc_r        <= tc_nxt_s;
         win_r       <= win_nxt_s;
         match_set_r <= hit_set_s;
         match_clr_r <= hit_clr_s;
      end
   end

   // Programming registers; a write only affects compares from the next cycle.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         period_r <= PERIOD_RST;
         setv_r   <= ONES_C;
         clrv_r   <= ONES_C;
      end else begin
         if (period_wr) begin
            period_r <= din;
         end
         if (set_wr) begin
            setv_r <= din;
         end
         if (clr_wr) begin
            clrv_r <= din;
         end
      end
   end

   assign cnt       = cnt_r;
   assign tc        = tc_r;
   assign win       = win_r;
   assign match_set = match_set_r;
   assign match_clr = match_clr_r;

endmodule

// File: tb/tb_vid_cnt11.sv
// Self-checking bench for vid_cnt11: a per-cycle behavioural model plus
// directed scenarios with hand-computed expectations.
module tb_vid_cnt11;

   logic        sys_clk = 1'b0;
   logic        reset   = 1'b1;
   logic        cnt_en  = 1'b0;
   logic [10:0] din     = 11'd0;
   logic        period_wr = 1'b0;
   logic        set_wr  = 1'b0;
   logic        clr_wr  = 1'b0;
   logic        cnt_clr = 1'b0;
   logic [10:0] cnt;
   logic        tc;
   logic        win;
   logic        match_set;
   logic        match_clr;

   int errors = 0;
   int checks = 0;

   vid_cnt11 dut (
      .sys_clk   (sys_clk),
      .reset     (reset),
      .cnt_en    (cnt_en),
      .din       (din),
      .period_wr (period_wr),
      .set_wr    (set_wr),
      .clr_wr    (clr_wr),
      .cnt_clr   (cnt_clr),
      .cnt       (cnt),
      .tc        (tc),
      .win       (win),
      .match_set (match_set),
      .match_clr (match_clr)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // Behavioural model: plain integers, count kept modulo 2048.
   int m_cnt = 0, m_period = 2047, m_setv = 2047, m_clrv = 2047;
   bit m_tc = 0, m_win = 0, m_ms = 0, m_mc = 0, armed = 0;

   always @(posedge sys_clk) begin
      if (reset) begin
         m_cnt = 0; m_tc = 0; m_win = 0; m_ms = 0; m_mc = 0;
         m_period = 2047; m_setv = 2047; m_clrv = 2047;
         armed = 1;
      end else begin
         m_ms = cnt_en && !cnt_clr && (m_cnt == m_setv);
         m_mc = cnt_en && !cnt_clr && (m_cnt == m_clrv);
         if (m_mc) m_win = 0;
         else if (m_ms) m_win = 1;
         if (cnt_clr) begin
            m_cnt = 0; m_tc = 0;
         end else if (cnt_en) begin
            m_tc  = (m_cnt == m_period);
            m_cnt = m_tc ? 0 : (m_cnt + 1) % 2048;
         end else begin
            m_tc = 0;
         end
         if (period_wr) m_period = int'(din);
         if (set_wr)    m_setv   = int'(din);
         if (clr_wr)    m_clrv   = int'(din);
      end
      #1;
      if (armed) begin
         chk("model_cnt", int'(cnt), m_cnt);
         chk("model_tc", int'(tc), int'(m_tc));
         chk("model_win", int'(win), int'(m_win));
         chk("model_match_set", int'(match_set), int'(m_ms));
         chk("model_match_clr", int'(match_clr), int'(m_mc));
      end
   end

   // One cycle: drive inputs, pass the rising edge, return at the falling edge.
   task automatic cyc(input bit en, input bit clr, input bit pw, input bit sw,
                      input bit cw, input logic [10:0] d);
      cnt_en = en; cnt_clr = clr; period_wr = pw; set_wr = sw; clr_wr = cw; din = d;
      @(posedge sys_clk);
      @(negedge sys_clk);
   endtask

   int tc_n, win_n, ms_n, mc_n;

   initial begin
      reset = 1'b1;
      repeat (2) cyc(0, 0, 0, 0, 0, 11'd0);
      chk("reset_cnt", int'(cnt), 0);
      chk("reset_tc", int'(tc), 0);
      chk("reset_win", int'(win), 0);
      reset = 1'b0;

      // Period 9, free run for 25 cycles: two wraps, ends at 5.
      cyc(0, 0, 1, 0, 0, 11'd9);
      tc_n = 0;
      for (int i = 0; i < 25; i++) begin
         cyc(1, 0, 0, 0, 0, 11'd0);
         tc_n += int'(tc);
      end
      chk("p9_tc_count", tc_n, 2);
      chk("p9_final_cnt", int'(cnt), 5);

      // Window set at 2, clear at 6: high for counts 3..6 of each period.
      cyc(0, 0, 0, 1, 0, 11'd2);
      cyc(0, 0, 0, 0, 1, 11'd6);
      cyc(0, 1, 0, 0, 0, 11'd0);
      win_n = 0; ms_n = 0; mc_n = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(1, 0, 0, 0, 0, 11'd0);
         win_n += int'(win);
         ms_n  += int'(match_set);
         mc_n  += int'(match_clr);
         if (i == 2) chk("win_rise_at_3", int'(win), 1);
         if (i == 6) chk("win_fall_at_7", int'(win), 0);
      end
      chk("win_high_cycles", win_n, 12);
      chk("match_set_pulses", ms_n, 3);
      chk("match_clr_pulses", mc_n, 3);

      // Period 3 with cnt_en alternating.
      cyc(0, 1, 1, 0, 0, 11'd3);
      tc_n = 0;
      for (int i = 0; i < 16; i++) begin
         cyc(i % 2 == 0, 0, 0, 0, 0, 11'd0);
         tc_n += int'(tc);
      end
      chk("toggle_tc_count", tc_n, 2);
      chk("toggle_final_cnt", int'(cnt), 0);

      // Period shrunk below the count: runs to 7FF, silent wrap, then wraps at 5.
      cyc(0, 0, 1, 0, 0, 11'd9);
      cyc(0, 1, 0, 0, 0, 11'd0);
      repeat (8) cyc(1, 0, 0, 0, 0, 11'd0);
      chk("shrink_start_cnt", int'(cnt), 8);
      cyc(1, 0, 1, 0, 0, 11'd5);
      chk("shrink_old_period_used", int'(cnt), 9);
      repeat (2038) cyc(1, 0, 0, 0, 0, 11'd0);
      chk("shrink_at_7ff", int'(cnt), 2047);
      cyc(1, 0, 0, 0, 0, 11'd0);
      chk("shrink_wrap_cnt", int'(cnt), 0);
      chk("shrink_wrap_no_tc", int'(tc), 0);
      repeat (5) cyc(1, 0, 0, 0, 0, 11'd0);
      chk("shrink_cnt5", int'(cnt), 5);
      cyc(1, 0, 0, 0, 0, 11'd0);
      chk("shrink_new_wrap_cnt", int'(cnt), 0);
      chk("shrink_new_wrap_tc", int'(tc), 1);

      // setv == clrv while win is high: clear wins. Then cnt_clr keeps win.
      cyc(0, 0, 1, 0, 0, 11'd9);
      cyc(0, 1, 0, 0, 0, 11'd0);
      repeat (3) cyc(1, 0, 0, 0, 0, 11'd0);
      chk("eq_pre_win", int'(win), 1);
      cyc(1, 0, 0, 1, 1, 11'd4);
      chk("eq_write_cnt", int'(cnt), 4);
      cyc(1, 0, 0, 0, 0, 11'd0);
      chk("eq_clear_wins", int'(win), 0);
      chk("eq_both_set", int'(match_set), 1);
      chk("eq_both_clr", int'(match_clr), 1);
      cyc(0, 0, 0, 1, 0, 11'd5);
      cyc(1, 0, 0, 0, 0, 11'd0);
      cyc(1, 0, 0, 0, 0, 11'd0);
      chk("cclr_pre_cnt", int'(cnt), 7);
      chk("cclr_pre_win", int'(win), 1);
      cyc(1, 1, 0, 0, 0, 11'd0);
      chk("cclr_cnt", int'(cnt), 0);
      chk("cclr_tc", int'(tc), 0);
      chk("cclr_win_kept", int'(win), 1);

      // Reset mid-count with win high; period returns to 7FF.
      cyc(0, 0, 1, 0, 0, 11'h7FF);
      cyc(0, 0, 0, 1, 1, 11'h3A0);
      cyc(0, 0, 0, 0, 1, 11'h7FE);
      cyc(0, 1, 0, 0, 0, 11'd0);
      repeat (933) cyc(1, 0, 0, 0, 0, 11'd0);
      chk("rst_mid_cnt", int'(cnt), 933);
      chk("rst_mid_win", int'(win), 1);
      reset = 1'b1;
      cyc(1, 0, 0, 0, 0, 11'd0);
      reset = 1'b0;
      chk("rst_mid_cnt0", int'(cnt), 0);
      chk("rst_mid_win0", int'(win), 0);
      chk("rst_mid_tc0", int'(tc), 0);
      repeat (2047) cyc(1, 0, 0, 0, 0, 11'd0);
      chk("rst_period_7ff_cnt", int'(cnt), 2047);
      chk("rst_period_7ff_notc", int'(tc), 0);
      cyc(1, 0, 0, 0, 0, 11'd0);
      chk("rst_period_wrap_cnt", int'(cnt), 0);
      chk("rst_period_wrap_tc", int'(tc), 1);
      cyc(0, 0, 0, 0, 0, 11'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
